// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern source and the sequence detector bench:
// state encoding and the word/length width helpers.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10
   } state_t;

   localparam int SEQ_WIDTH = 8;
   localparam int SEQ_LEN_W = $clog2(SEQ_WIDTH + 1);

   // Width of a length field able to hold 0..width.
   function automatic int len_bits(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_pattern_source_bit_tick_gen.sv
// Bit-period counter: counts 0..BIT_TICKS-1 and flags the last cycle of each period.
module bit_tick_gen
   import seq_pkg::*;
#(
   parameter int BIT_TICKS = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(BIT_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (clear || cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/serial_pattern_source.sv
// Parallel-to-serial stimulus source: shifts a word out MSB first on ain, one bit per
// BIT_TICKS cycles, followed by GAP_BITS forced-zero bits so successive words stay separate.
module serial_pattern_source
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BIT_TICKS = 1,
   parameter int GAP_BITS  = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [WIDTH-1:0]             din,
   input  logic [len_bits(WIDTH)-1:0]   len,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic                         flush,
   output logic                         ain,
   output logic                         busy,
   output logic                         done
);

   localparam int LW = len_bits(WIDTH);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = 4;
   localparam logic [GW-1:0] GAP_LAST = (GAP_BITS > 0) ? GW'(GAP_BITS - 1) : '0;

   state_t            state_reg;
   logic [WIDTH-1:0]  sr_reg;
   logic [BW-1:0]     bit_cnt_reg;
   logic [GW-1:0]     gap_cnt_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              tick;

   logic [LW-1:0]     eff_len;
   logic [LW-1:0]     shift_amt;
   logic [WIDTH-1:0]  load_word;
   logic [BW-1:0]     bit_load;

   // Left-align the selected bits so the first bit to send sits in the MSB; the zeros
   // shifted in behind them leave the register clear once the word is out.
   always_comb begin
      eff_len   = (len == '0) ? LW'(WIDTH) : len;
      shift_amt = LW'(WIDTH) - eff_len;
      load_word = din << shift_amt;
      bit_load  = BW'(eff_len - LW'(1));
   end

   bit_tick_gen #(
      .BIT_TICKS (BIT_TICKS)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   ((state_reg == IDLE) || flush),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         sr_reg      <= '0;
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (flush) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (din_valid) begin
                     state_reg   <= SHIFT;
                     sr_reg      <= load_word;
                     bit_cnt_reg <= bit_load;
                     busy_reg    <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (tick) begin
                     sr_reg <= {sr_reg[WIDTH-2:0], 1'b0};
                     if (bit_cnt_reg == '0) begin
                        if (GAP_BITS == 0) begin
                           state_reg <= IDLE;
                           busy_reg  <= 1'b0;
                           done_reg  <= 1'b1;
                        end else begin
                           state_reg   <= GAP;
                           gap_cnt_reg <= GAP_LAST;
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                     end
                  end
               end
               GAP: begin
                  if (tick) begin
                     if (gap_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   // ain is the MSB flop of the shift register, which is zero outside SHIFT.
   assign ain       = sr_reg[WIDTH-1];
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign din_ready = reset_n && !flush && (state_reg == IDLE);

endmodule

// File: tb/tb_serial_pattern_source.sv
// Scoreboard bench: four parameter sets run side by side, each with a per-cycle expected
// output timeline built from the word/bit-period/gap rules and checked by a monitor.
module tb_serial_pattern_source;

   localparam logic [3:0][7:0] CFG_W  = {8'd16, 8'd5, 8'd8, 8'd8};
   localparam logic [3:0][7:0] CFG_BT = {8'd4,  8'd2, 8'd3, 8'd1};
   localparam logic [3:0][7:0] CFG_G  = {8'd2,  8'd0, 8'd1, 8'd1};

   typedef struct packed {
      logic ain;
      logic busy;
      logic done;
      logic rdy;
   } exp_t;

   logic clk;
   int   compared;
   int   mismatched;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      compared   = 0;
      mismatched = 0;
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int W  = int'(CFG_W[gi]);
      localparam int BT = int'(CFG_BT[gi]);
      localparam int G  = int'(CFG_G[gi]);
      localparam int LW = $clog2(W + 1);

      logic          reset_n;
      logic          flush;
      logic          din_valid;
      logic          din_ready;
      logic          ain;
      logic          busy;
      logic          done;
      logic [W-1:0]  din;
      logic [LW-1:0] len;
      exp_t          plan[$];
      exp_t          expq[$];
      int            cyc;
      bit            fin_b;

      serial_pattern_source #(
         .WIDTH     (W),
         .BIT_TICKS (BT),
         .GAP_BITS  (G)
      ) dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .din       (din),
         .len       (len),
         .din_valid (din_valid),
         .din_ready (din_ready),
         .flush     (flush),
         .ain       (ain),
         .busy      (busy),
         .done      (done)
      );

      // Expected output for every cycle of one accepted word, starting after the handshake.
      task automatic build(input logic [W-1:0] d, input logic [LW-1:0] l);
         int   n;
         exp_t e;
         n = (l == '0) ? W : int'(l);
         for (int k = n - 1; k >= 0; k--) begin
            for (int t = 0; t < BT; t++) begin
               e = '0; e.ain = d[k]; e.busy = 1'b1;
               plan.push_back(e);
            end
         end
         for (int t = 0; t < G * BT; t++) begin
            e = '0; e.busy = 1'b1;
            plan.push_back(e);
         end
         e = '0; e.done = 1'b1;
         plan.push_back(e);
      endtask

      task automatic step(input logic r, input logic f, input logic v,
                          input logic [W-1:0] d, input logic [LW-1:0] l, output bit acc);
         exp_t cur;
         @(posedge clk);
         acc = 1'b0;
         if (!reset_n || flush) begin
            plan.delete();
         end else if (plan.size() == 0 && din_valid) begin
            build(din, len);
            acc = 1'b1;
         end
         if (plan.size() > 0) cur = plan.pop_front();
         else cur = '0;
         #1;
         reset_n = r; flush = f; din_valid = v; din = d; len = l;
         if (!reset_n) begin
            plan.delete();
            cur = '0;
         end
         cur.rdy = reset_n && !flush && !cur.busy;
         expq.push_back(cur);
         cyc++;
      endtask

      task automatic idle_steps(input int n);
         bit acc;
         for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, acc);
      endtask

      task automatic wait_idle(input int extra);
         int n;
         n = 0;
         while (plan.size() != 0 && n < 2000) begin
            idle_steps(1);
            n++;
         end
         idle_steps(extra);
      endtask

      task automatic send_word(input logic [W-1:0] d, input logic [LW-1:0] l);
         bit acc;
         int n;
         n = 0;
         do begin
            step(1'b1, 1'b0, 1'b1, d, l, acc);
            n++;
         end while (!acc && n < 2000);
         if (!acc) begin
            mismatched++;
            $display("FAIL cfg%0d handshake_timeout: got no acceptance, required one within 2000 cycles", gi);
         end
      endtask

      initial begin : drv
         bit            acc;
         bit            pending;
         logic [W-1:0]  pd;
         logic [LW-1:0] pl;
         logic          r;
         logic          f;
         fin_b = 1'b0; cyc = 0;
         reset_n = 1'b0; flush = 1'b0; din_valid = 1'b0; din = '0; len = '0;
         step(1'b0, 1'b0, 1'b0, '0, '0, acc);
         step(1'b0, 1'b0, 1'b0, '0, '0, acc);
         idle_steps(2);
         // basic shift, programmed bit period/length, back-to-back with valid held
         send_word(W'(8'hF0), '0);
         wait_idle(2);
         send_word(W'(8'h05), LW'(3));
         wait_idle(2);
         send_word({W{1'b1}}, LW'((W < 7) ? W : 7));
         send_word({W{1'b1}}, LW'((W < 7) ? W : 7));
         wait_idle(2);
         // flush wins over a valid word in IDLE, then flush part-way through a word
         step(1'b1, 1'b1, 1'b1, W'(8'hA5), '0, acc);
         step(1'b1, 1'b1, 1'b1, W'(8'hA5), '0, acc);
         idle_steps(2);
         send_word(W'(8'hC3), '0);
         idle_steps(2 * BT);
         step(1'b1, 1'b1, 1'b0, '0, '0, acc);
         idle_steps(3);
         // asynchronous reset mid-word
         send_word(W'(8'hB5), '0);
         idle_steps(3 * BT - 1);
         step(1'b0, 1'b0, 1'b0, '0, '0, acc);
         step(1'b0, 1'b0, 1'b0, '0, '0, acc);
         idle_steps(2);
         send_word(W'(3'b101), LW'(3));
         wait_idle(2);
         // randomized traffic with occasional flush and reset
         pending = 1'b0; pd = '0; pl = '0;
         for (int c = 0; c < 1500; c++) begin
            if (!pending && $urandom_range(0, 2) == 0) begin
               pending = 1'b1;
               pd = W'($urandom);
               pl = LW'($urandom_range(0, W));
            end
            f = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 499) != 0);
            step(r, f, pending, pd, pl, acc);
            if (acc) pending = 1'b0;
            if (!r) pending = 1'b0;
         end
         wait_idle(3);
         fin_b = 1'b1;
      end

      initial begin : mon
         exp_t e;
         forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               compared++;
               if ({ain, busy, done, din_ready} !== e) begin
                  mismatched++;
                  $display("FAIL cfg%0d outputs cycle %0d: got ain=%b busy=%b done=%b din_ready=%b, required ain=%b busy=%b done=%b din_ready=%b",
                           gi, cyc, ain, busy, done, din_ready, e.ain, e.busy, e.done, e.rdy);
               end
            end
         end
      end
   end

   initial begin : master
      bit all_fin;
      all_fin = 1'b0;
      for (int c = 0; c < 60000 && !all_fin; c++) begin
         @(posedge clk);
         all_fin = g_cfg[0].fin_b && g_cfg[1].fin_b && g_cfg[2].fin_b && g_cfg[3].fin_b;
      end
      if (!all_fin) begin
         mismatched++;
         $display("FAIL run_timeout: got unfinished stimulus, required completion within 60000 cycles");
      end
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_pattern_source.md
# serial_pattern_source

Upstream stimulus stage for the sequence detector: accepts a parallel word over a valid/ready handshake and shifts it out as a one-bit serial stream on `ain`, one bit per programmable bit period. After every word it inserts a run of forced-zero gap bits, so consecutive words reach the detector's run-of-ones counter as separate runs. It replaces hand-timed bit stimulus with a reusable, cycle-exact source for both lab benches and on-board pattern playback.

## Interface
- `WIDTH`, 8: maximum word length in bits (2..16).
- `BIT_TICKS`, 1: clock cycles each serial bit is held (1..255).
- `GAP_BITS`, 1: zero bits driven after each word (0..15).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `din` in WIDTH: parallel word; bits `din[len-1]` down to `din[0]` are sent, MSB first.
- `len` in $clog2(WIDTH+1): number of bits to send; 0 means WIDTH.
- `din_valid` in 1: word/len valid.
- `din_ready` out 1: source can accept a word.
- `flush` in 1: synchronous abort.
- `ain` out 1: serial bit to the detector.
- `busy` out 1: in SHIFT or GAP.
- `done` out 1: one-cycle pulse when a word and its gap have completed.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `ain`=0, `din_ready`=1 when `flush`=0. Handshake fires when `din_valid && din_ready` on a clock edge. `din` and the effective length are captured into a shift register and bit counter, and the state moves to SHIFT.
- SHIFT: `ain` = current MSB of the selected bits, held for BIT_TICKS cycles. Then the next bit is sent. After the last bit, the state moves to GAP, or to IDLE if GAP_BITS=0.
- GAP: `ain`=0 for GAP_BITS×BIT_TICKS cycles, then the state moves to IDLE.
- `done` pulses in the cycle the state returns to IDLE after a normal completion.
- `din_ready` is 0 in SHIFT and GAP. Words offered while busy are neither captured nor dropped; `din_valid` must be held.
- `flush`=1 in any state: the state returns to IDLE at the next edge, `ain`=0, and no `done` pulse occurs. If `flush` and `din_valid` are both high in IDLE, `flush` wins and the word is not accepted.
- Counters:
  - tick counter: $clog2(BIT_TICKS+1) bits, counts 0..BIT_TICKS-1 and wraps to 0 at each bit boundary.
  - bit counter: counts down from len-1 to 0.
  - gap counter: counts down from GAP_BITS-1 to 0.
  - No counter ever wraps past its terminal value.
- Reset (asynchronous, any state, including mid-word): state=IDLE; `ain`=0, `busy`=0, `done`=0; all counters and the shift register are 0. `din_ready`=1 as soon as `reset_n`=1 and `flush`=0.

## Timing
- Handshake at edge E: first bit appears on `ain` after edge E. `busy`=1 from E.
- Bit k (k=0 is the first bit) is valid from E+k·BIT_TICKS through E+(k+1)·BIT_TICKS−1.
- Word of L bits: SHIFT lasts L·BIT_TICKS cycles and GAP lasts GAP_BITS·BIT_TICKS cycles. `done` is high during the cycle starting at E+(L+GAP_BITS)·BIT_TICKS, and `din_ready` is 1 in that same cycle.
- Minimum spacing between handshakes is (L+GAP_BITS)·BIT_TICKS cycles, because the next word can be accepted at the `done` edge.
- All outputs are registered, except `din_ready`, which is decoded from state and `flush`.

## Structure
- Package `seq_pkg` holds:
  - the state encoding: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10;
  - the `WIDTH` and `len` width helper constants shared with the sequence detector bench.
- Sub-module `bit_tick_gen`: a BIT_TICKS period counter with a `clear` input and a `tick` output that pulses on the last cycle of each bit period. It is instantiated once.
- Top level contains the FSM, the shift register, and the bit and gap counters.

## Test plan
- Reset mid-word: WIDTH=8, BIT_TICKS=1, word 8'hB5 accepted, `reset_n` low after 3 bits -> `ain`=0, `busy`=0 immediately, no `done`; `din_ready`=1 after release.
- Basic shift: BIT_TICKS=1, GAP_BITS=1, `din`=8'hF0, `len`=0 -> `ain` sequence 1,1,1,1,0,0,0,0 then gap 0; `done` pulses 9 cycles after the handshake.
- Bit period and length: BIT_TICKS=3, `din`=8'h05, `len`=3 -> `ain` reads 1,1,1,0,0,0,1,1,1, then 3 gap cycles of 0, then `done`.
- Back-to-back: two words 8'hFF with `len`=7 and `din_valid` held high -> the second handshake occurs in the `done` cycle, and exactly GAP_BITS·BIT_TICKS zero cycles separate the two 7-bit runs of ones (detector `count` should reach 7 twice).
- Flush priority: `flush`=1 together with `din_valid`=1 in IDLE -> no capture, `busy` stays 0. Then `flush` during SHIFT -> IDLE next cycle, `ain`=0, no `done`.
- GAP_BITS=0: word 3'b101, `len`=3 -> `ain` reads 1,0,1, then IDLE with `ain`=0 and `done` in the cycle after the last bit.
